// File: rtl/data_memory_if.sv
// Bus bundle for the data RAM: one write port (we/waddr/wdata) and one
// combinational read port (raddr/rdata).
interface data_memory_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rdata;

    modport master (
        output we, waddr, wdata, raddr,
        input  rdata
    );

    modport slave (
        input  we, waddr, wdata, raddr,
        output rdata
    );
endinterface

// File: rtl/data_memory.sv
// Word-addressed data RAM: synchronous write, combinational read, and an
// asynchronous clear of every word while rst is high.
module data_memory #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic          clk,
    input  logic          rst,
    data_memory_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] widx;
    logic [DEPTH_LOG2-1:0] ridx;

    // Upper address bits are dropped, so addresses alias modulo DEPTH.
    assign widx = bus.waddr[DEPTH_LOG2-1:0];
    assign ridx = bus.raddr[DEPTH_LOG2-1:0];

    generate
        if (ADDR_W > DEPTH_LOG2) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^{bus.waddr[ADDR_W-1:DEPTH_LOG2],
                                      bus.raddr[ADDR_W-1:DEPTH_LOG2]};
        end
    endgenerate

    // NOTE: this memory is deliberately reset word-by-word because an
    // immediate clear to zero is part of its contract; that keeps it out of
    // block RAM, so don't copy this pattern onto RAMs that don't need it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                // NOTE: non-blocking for all sequential state, so every
                // always_ff sees pre-edge values regardless of block order.
                mem[i] <= '0;
            end
        end else if (bus.we) begin
            mem[widx] <= bus.wdata;
        end
    end

    // The forced zero also covers the instant rst rises, before the clear lands.
    assign bus.rdata = rst ? '0 : mem[ridx];
endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: a queue of expected read values is filled as
// each stimulus step is driven and drained as the read port is sampled.
module tb_data_memory;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int DEPTH_LOG2 = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    data_memory_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    data_memory #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .DEPTH_LOG2(DEPTH_LOG2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] sb [$];
    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic compare_next(input string tag);
        logic [DATA_W-1:0] exp;
        exp = sb.pop_front();
        n_compared++;
        assert (bus.rdata === exp) else begin
            n_mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, bus.rdata, exp);
        end
    endtask

    task automatic expect_read(input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] exp,
                               input string tag);
        sb.push_back(exp);
        bus.raddr = addr;
        #1;
        compare_next(tag);
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] data);
        @(negedge clk);
        bus.we    = 1'b1;
        bus.waddr = addr;
        bus.wdata = data;
        @(negedge clk);
        bus.we    = 1'b0;
    endtask

    initial begin
        bus.we    = 1'b0;
        bus.waddr = '0;
        bus.wdata = '0;
        bus.raddr = '0;

        // Reset state
        #1;
        expect_read(32'd0, 32'h0, "rst_held_rdata");
        @(negedge clk);
        rst = 1'b0;
        expect_read(32'd200, 32'h0, "post_rst_word200");

        // Mid-cycle reset pulse with no clock edge
        do_write(32'd0,   32'h0000_0011);
        do_write(32'd5,   32'h0000_0055);
        do_write(32'd255, 32'h0000_00FF);
        expect_read(32'd5, 32'h0000_0055, "prefill_word5");
        @(negedge clk);
        #1 rst = 1'b1;
        expect_read(32'd5, 32'h0, "during_pulse_word5");
        rst = 1'b0;
        expect_read(32'd0,   32'h0, "pulse_clear_word0");
        expect_read(32'd5,   32'h0, "pulse_clear_word5");
        expect_read(32'd255, 32'h0, "pulse_clear_word255");

        // Write then read, neighbour untouched
        do_write(32'd3, 32'hDEAD_BEEF);
        expect_read(32'd3, 32'hDEAD_BEEF, "write_read_word3");
        expect_read(32'd4, 32'h0, "neighbour_word4");

        // Write disabled
        @(negedge clk);
        bus.we    = 1'b0;
        bus.waddr = 32'd3;
        bus.wdata = 32'h1234_5678;
        @(negedge clk);
        expect_read(32'd3, 32'hDEAD_BEEF, "we_low_word3");

        // we pulse between edges is ignored
        @(negedge clk);
        bus.we    = 1'b1;
        bus.waddr = 32'd9;
        bus.wdata = 32'hBAD0_BAD0;
        #2 bus.we = 1'b0;
        @(negedge clk);
        expect_read(32'd9, 32'h0, "glitch_we_word9");

        // Same-address read during write
        do_write(32'd7, 32'h1);
        @(negedge clk);
        bus.we    = 1'b1;
        bus.waddr = 32'd7;
        bus.wdata = 32'h2;
        expect_read(32'd7, 32'h1, "raw_before_edge");
        @(posedge clk);
        sb.push_back(32'h2);
        #1;
        compare_next("raw_after_edge");
        bus.we = 1'b0;
        expect_read(32'd3, 32'hDEAD_BEEF, "other_word_kept");

        // Aliasing on upper address bits
        do_write(32'h0000_0102, 32'hA5A5_A5A5);
        expect_read(32'd2,          32'hA5A5_A5A5, "alias_raddr2");
        expect_read(32'hFFFF_FF02, 32'hA5A5_A5A5, "alias_raddr_hi");

        // Reset mid-operation, write during reset dropped
        do_write(32'd0, 32'h1000_0000);
        do_write(32'd1, 32'h1000_0001);
        do_write(32'd2, 32'h1000_0002);
        do_write(32'd3, 32'h1000_0003);
        expect_read(32'd2, 32'h1000_0002, "fill_word2");
        @(negedge clk);
        #1 rst = 1'b1;
        bus.we    = 1'b1;
        bus.waddr = 32'd1;
        bus.wdata = 32'h0000_0777;
        for (int i = 0; i < 4; i++) begin
            expect_read(32'(i), 32'h0, $sformatf("rst_clear_word%0d", i));
        end
        @(negedge clk);
        bus.we = 1'b0;
        rst    = 1'b0;
        expect_read(32'd1, 32'h0, "write_in_rst_dropped");

        // First write after reset release
        do_write(32'd1, 32'h0000_0055);
        expect_read(32'd1, 32'h0000_0055, "first_write_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
